regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16-entry register bank between NUM_REQ requesters (ALU result, load path, link writer, debug/console).
- Round-robin arbitration with a registered write stage.
- Drives a 4-bit write address, which the existing 4-to-16 one-hot decoder turns into per-register write enables, plus write data and a write strobe.
- Returns a one-cycle grant pulse to the winning requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, register width.
- ADDR_W, 4, register address width (fixed at 4 for the 16-register bank).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req  in  NUM_REQ  per-requester write request; held high until granted.
- req_addr  in  NUM_REQ*ADDR_W  packed target register per requester; slice i belongs to req[i].
- req_data  in  NUM_REQ*DATA_W  packed write data per requester.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse, coincident with wr_en.
- wr_en  out  1  register-bank write strobe.
- wr_addr  out  ADDR_W  register index to the one-hot decoder.
- wr_data  out  DATA_W  write data.
- busy  out  1  high while in WRITE state.

Behaviour:
- Reset is asynchronous: state=IDLE, rr_ptr=0, gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0.
- FSM has two states, IDLE and WRITE. All outputs are registered.
- Arbitration runs at every rising edge over eligible = req & ~gnt. The just-granted requester is masked because its req is still high in its grant cycle.
- Winner = first set bit of eligible, searching upward from rr_ptr and wrapping modulo NUM_REQ.
- IDLE:
  - eligible==0: stay in IDLE, outputs stay 0.
  - Otherwise: latch the winner's addr and data into wr_addr and wr_data, set gnt[winner]=1, wr_en=1, busy=1, go to WRITE.
- WRITE (one cycle per write):
  - rr_ptr <= (winner+1) mod NUM_REQ, where winner is the requester granted in this cycle.
  - If eligible!=0: stay in WRITE with the new winner (back-to-back writes, one per cycle).
  - Else: go to IDLE and clear gnt, wr_en and busy.
- Latency: req sampled high at edge n gives wr_en/gnt high during the cycle after edge n (one cycle).
- Requester rule: deassert req, or present a new addr/data, in the cycle after gnt.
  - A req still high after its grant cycle is a new request.
  - It is eligible again only after the other pending requesters, per round-robin order.
- Fairness: with all NUM_REQ requesting continuously, grants rotate and each requester gets exactly one grant per NUM_REQ cycles.
- Simultaneous requests: resolved purely by rr_ptr. There is no fixed priority.
- wr_addr and wr_data hold their last values when wr_en=0. Consumers qualify them with wr_en.
- Address range: any index 0..15, including 15, is passed through unmodified unless the optional feature is enabled.
- Reset mid-write: the write in flight is dropped (wr_en falls immediately, asynchronously) and no gnt is issued. Requesters must re-request.

Optional Feature:
- Macro: REGFILE_PC_PROTECT_EN
- Defined:
  - A winner from requester index !=0 targeting register 15 still receives gnt (so it does not hang), but wr_en stays 0 in that cycle.
  - An extra output pc_viol (1 bit, reset 0) pulses high for that cycle.
  - Requester 0 may always write R15.
- Not defined: no pc_viol port; all addresses are written normally.

Decomposition:
- Shared package regfile_pkg holds:
  - REG_COUNT=16, REG_ADDR_W=4, PC_INDEX=15;
  - the state encoding (IDLE=1'b0, WRITE=1'b1);
  - default DATA_W=32.
- Sub-module rr_pick (combinational):
  - inputs eligible and rr_ptr;
  - outputs winner index and a valid flag.
  - Instantiated once; the registered stage and FSM stay in the top.

Test Plan:
- Single request: after reset, req=4'b0001, addr0=4'd3, data0=32'hDEADBEEF for 1 cycle. Expect one cycle later wr_en=1, wr_addr=3, wr_data=DEADBEEF, gnt=0001, then IDLE.
- Simultaneous requests: req=4'b1111 held, each dropping its req the cycle after its gnt. Expect gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles, wr_en high 4 cycles, busy falling after the 4th.
- Round-robin continuity: req=0011 held continuously with rr_ptr=0. Expect gnt alternating 0001, 0010, 0001, ... and never the same bit twice in a row.
- Wrap: rr_ptr=3 (after granting requester 2), then req=1001. Expect gnt=1000 first, then 0001.
- Async reset mid-burst: req=1111, assert rst asynchronously during the 2nd grant. Expect wr_en, gnt, busy = 0 immediately and rr_ptr=0, with the next grant after release going to requester 0.
- With REGFILE_PC_PROTECT_EN: req=0010, addr1=15. Expect gnt=0010, wr_en=0, pc_viol=1 for one cycle. Same request from requester 0 gives wr_en=1, wr_addr=15.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-bank write arbiter.
package regfile_pkg;

    localparam int REG_COUNT      = 16;
    localparam int REG_ADDR_W     = 4;
    localparam int PC_INDEX       = 15;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_e;

    function automatic logic pc_target(input logic [REG_ADDR_W-1:0] addr);
        return addr == REG_ADDR_W'(PC_INDEX);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bus and register-bank write port of the write arbiter.
// REGFILE_PC_PROTECT_EN adds the pc_viol pulse.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic                      busy;
`ifdef REGFILE_PC_PROTECT_EN
    logic                      pc_viol;

    modport master (output req, req_addr, req_data,
                    input  gnt, wr_en, wr_addr, wr_data, busy, pc_viol);
    modport slave  (input  req, req_addr, req_data,
                    output gnt, wr_en, wr_addr, wr_data, busy, pc_viol);
`else
    modport master (output req, req_addr, req_data,
                    input  gnt, wr_en, wr_addr, wr_data, busy);
    modport slave  (input  req, req_addr, req_data,
                    output gnt, wr_en, wr_addr, wr_data, busy);
`endif
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Round-robin picker: first eligible requester at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    // Scan offsets from the far end down so the nearest eligible index wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int               cand;
            logic [IDX_W-1:0] cand_i;
            cand   = int'(rr_ptr) + k;
            cand   = (cand >= NUM_REQ) ? (cand - NUM_REQ) : cand;
            cand_i = IDX_W'(cand);
            winner = eligible[cand_i] ? cand_i : winner;
            valid  = valid | eligible[cand_i];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port, registered write stage.
// Optional REGFILE_PC_PROTECT_EN blocks R15 writes from requesters other than 0.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [IDX_W-1:0]    gnt_idx_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic                wr_en_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                busy_r;

    logic [NUM_REQ-1:0]  eligible_s;
    logic [IDX_W-1:0]    pick_win_s;
    logic                pick_valid_s;
    logic [NUM_REQ-1:0]  win_onehot_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [IDX_W-1:0]    ptr_next_s;
    logic                blk_s;

    // The requester holding the grant still has req high, so it sits out this edge.
    assign eligible_s = bus.req & ~gnt_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible (eligible_s),
        .rr_ptr   (rr_ptr_r),
        .winner   (pick_win_s),
        .valid    (pick_valid_s)
    );

    // Select the winner's address/data and form its one-hot grant.
    always_comb begin
        sel_addr_s   = '0;
        sel_data_s   = '0;
        win_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s      = (pick_win_s == IDX_W'(i)) ? bus.req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
            sel_data_s      = (pick_win_s == IDX_W'(i)) ? bus.req_data[i*DATA_W +: DATA_W] : sel_data_s;
            win_onehot_s[i] = pick_valid_s && (pick_win_s == IDX_W'(i));
        end
    end

    assign ptr_next_s = (gnt_idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : (gnt_idx_r + IDX_W'(1));

`ifdef REGFILE_PC_PROTECT_EN
    logic pc_viol_r;

    assign blk_s       = (pick_win_s != '0) && pc_target(sel_addr_s);
    assign bus.pc_viol = pc_viol_r;

    // Violation pulse accompanies the suppressed write's grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_viol_r <= 1'b0;
        end else begin
            pc_viol_r <= pick_valid_s & blk_s;
        end
    end
`else
    assign blk_s = 1'b0;
`endif

    // Two-state write FSM with the registered grant/write stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            rr_ptr_r  <= '0;
            gnt_idx_r <= '0;
            gnt_r     <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= pick_valid_s ? ST_WRITE : ST_IDLE;
                end
                ST_WRITE: begin
                    rr_ptr_r <= ptr_next_s;
                    state_r  <= pick_valid_s ? ST_WRITE : ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
            gnt_r   <= win_onehot_s;
            wr_en_r <= pick_valid_s & ~blk_s;
            busy_r  <= pick_valid_s;
            // Address/data hold their last value when no write is issued.
            if (pick_valid_s) begin
                gnt_idx_r <= pick_win_s;
                wr_addr_r <= sel_addr_s;
                wr_data_r <= sel_data_s;
            end else begin
                gnt_idx_r <= gnt_idx_r;
            end
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;
    assign bus.busy    = busy_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven, scoreboarded bench for regfile_write_arbiter (4 requesters, 32-bit data).
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_write_arbiter_if #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(4)) bus ();

    regfile_write_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        int          keep;      // 0: drop each req the cycle after its grant; N: hold N cycles
        bit          rst_first;
        int          len;
        logic [15:0] addrs;
        logic [31:0] data0;
        logic [39:0] gseq;      // expected gnt per cycle, cycle 0 in the low nibble
    } vec_t;

    typedef struct {
        logic [3:0]  gnt;
        logic        wr_en;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        busy;
        logic        pc_viol;
    } exp_t;

    vec_t        vecs [6];
    exp_t        sb [$];
    logic [31:0] dat [4];
    logic [3:0]  last_addr;
    logic [31:0] last_data;
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic load_bus(input logic [15:0] addrs);
        bus.req_addr = addrs;
        for (int i = 0; i < 4; i++) bus.req_data[i*32 +: 32] = dat[i];
    endtask

    function automatic exp_t make_exp(input logic [3:0] g, input logic [15:0] addrs);
        exp_t e;
        int   idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        e.gnt     = g;
        e.busy    = (g != 4'b0000);
        e.wr_en   = e.busy;
        e.pc_viol = 1'b0;
        if (e.busy) begin
            last_addr = addrs[idx*4 +: 4];
            last_data = dat[idx];
`ifdef REGFILE_PC_PROTECT_EN
            if (idx != 0 && last_addr == 4'd15) begin
                e.wr_en   = 1'b0;
                e.pc_viol = 1'b1;
            end
`endif
        end
        e.addr = last_addr;
        e.data = last_data;
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        e = sb.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("wr_en", 32'(bus.wr_en), 32'(e.wr_en));
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
        chk("busy", 32'(bus.busy), 32'(e.busy));
`ifdef REGFILE_PC_PROTECT_EN
        chk("pc_viol", 32'(bus.pc_viol), 32'(e.pc_viol));
`endif
    endtask

    initial begin
        logic [3:0] acc;
        logic [3:0] prev_g;
        logic [3:0] g;

        vecs[0] = '{mask:4'b0001, keep:0, rst_first:1'b1, len:3, addrs:16'h0003, data0:32'hDEADBEEF, gseq:40'h0000000001};
        vecs[1] = '{mask:4'b1111, keep:0, rst_first:1'b1, len:6, addrs:16'hF7A3, data0:32'h1111_0000, gseq:40'h0000008421};
        vecs[2] = '{mask:4'b0011, keep:6, rst_first:1'b0, len:8, addrs:16'h00C5, data0:32'h2222_0000, gseq:40'h0000212121};
        vecs[3] = '{mask:4'b0100, keep:0, rst_first:1'b0, len:3, addrs:16'h0E00, data0:32'h3333_0000, gseq:40'h0000000004};
        vecs[4] = '{mask:4'b1001, keep:0, rst_first:1'b0, len:4, addrs:16'hF001, data0:32'h4444_0000, gseq:40'h0000000018};
        vecs[5] = '{mask:4'b1111, keep:8, rst_first:1'b0, len:9, addrs:16'h246F, data0:32'h5555_0000, gseq:40'h0018421842};

        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        last_addr    = '0;
        last_data    = '0;

        // Reset state while rst is held, then just after release
        #2;
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        do_reset();
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
        chk("rst_wr_data", bus.wr_data, 32'h0);

        // Table-driven sequences; rr_ptr carries over between entries without reset
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].rst_first) do_reset();
            dat[0] = vecs[v].data0;
            for (int i = 1; i < 4; i++) dat[i] = $urandom;
            load_bus(vecs[v].addrs);
            acc    = 4'b0000;
            prev_g = 4'b0000;
            for (int c = 0; c < vecs[v].len; c++) begin
                if (vecs[v].keep != 0) begin
                    bus.req = (c < vecs[v].keep) ? vecs[v].mask : 4'b0000;
                end else begin
                    bus.req = vecs[v].mask & ~acc;
                    acc     = acc | prev_g;
                end
                g      = vecs[v].gseq[c*4 +: 4];
                prev_g = g;
                sb.push_back(make_exp(g, vecs[v].addrs));
                @(posedge clk);
                @(negedge clk);
                compare_out();
            end
            bus.req = '0;
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);

        // Asynchronous reset during the second grant of a burst
        do_reset();
        dat[0] = 32'hA0A0_0000; dat[1] = 32'hA1A1_1111; dat[2] = 32'hA2A2_2222; dat[3] = 32'hA3A3_3333;
        load_bus(16'h3210);
        bus.req = 4'b1111;
        @(negedge clk);
        chk("ar_gnt1", 32'(bus.gnt), 32'h1);
        @(posedge clk);
        #1;
        chk("ar_gnt2", 32'(bus.gnt), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("ar_wr_en", 32'(bus.wr_en), 32'h0);
        chk("ar_gnt", 32'(bus.gnt), 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_regrant", 32'(bus.gnt), 32'h1);
        chk("ar_regrant_data", bus.wr_data, 32'hA0A0_0000);
        bus.req = '0;
        repeat (2) @(negedge clk);
        chk("ar_idle", 32'(bus.busy), 32'h0);

`ifdef REGFILE_PC_PROTECT_EN
        // Non-zero requester targeting R15 is granted but the write is suppressed
        do_reset();
        dat[1] = 32'hBADC_0FFE;
        load_bus(16'h00F0);
        bus.req = 4'b0010;
        @(negedge clk);
        chk("pc_gnt", 32'(bus.gnt), 32'h2);
        chk("pc_wr_en", 32'(bus.wr_en), 32'h0);
        chk("pc_viol", 32'(bus.pc_viol), 32'h1);
        @(negedge clk);
        bus.req = '0;
        chk("pc_viol_pulse", 32'(bus.pc_viol), 32'h0);
        @(negedge clk);
        load_bus(16'h000F);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("pc_r0_wr_en", 32'(bus.wr_en), 32'h1);
        chk("pc_r0_addr", 32'(bus.wr_addr), 32'hF);
        chk("pc_r0_viol", 32'(bus.pc_viol), 32'h0);
        bus.req = '0;
        repeat (2) @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
